// File: rtl/axis_crc32_word_packer.sv
// Packs an 8-bit AXI-Stream byte stream into padded 32-bit words for the CRC-32 engine.
// Optional frame statistics outputs are built when CRC_PACKER_STATS_EN is defined.
module axis_crc32_word_packer #(
    parameter int         OUT_BYTES = 4,
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        frame_done
`ifdef CRC_PACKER_STATS_EN
    ,
    output logic [15:0] frame_bytes,
    output logic [15:0] frame_count
`endif
);

    if (OUT_BYTES != 4) begin : g_bad_out_bytes
        $error("axis_crc32_word_packer supports only OUT_BYTES == 4");
    end

    logic [31:0] acc_data;
    logic [3:0]  acc_keep;
    logic [1:0]  idx;
    logic [1:0]  lane;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        accept;
    logic        word_done;
    logic        drain;

    // The output register can take a new word whenever it is empty or draining this cycle.
    assign s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign word_done     = accept && ((idx == 2'd3) || s_axis_tlast);
    assign drain         = m_axis_tvalid && m_axis_tready;
    assign lane          = MSB_FIRST ? (2'd3 - idx) : idx;

    always_comb begin
        word_data                 = acc_data;
        word_data[8*lane +: 8]    = s_axis_tdata;
        word_keep                 = acc_keep | (4'b0001 << lane);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_data      <= {4{PAD_BYTE}};
            acc_keep      <= 4'b0000;
            idx           <= 2'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 32'h0;
            m_axis_tkeep  <= 4'b0000;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= drain && m_axis_tlast;

            if (word_done) begin
                m_axis_tdata <= word_data;
                m_axis_tkeep <= word_keep;
                m_axis_tlast <= s_axis_tlast;
                acc_data     <= {4{PAD_BYTE}};
                acc_keep     <= 4'b0000;
                idx          <= 2'd0;
            end else if (accept) begin
                acc_data <= word_data;
                acc_keep <= word_keep;
                idx      <= idx + 2'd1;
            end

            // A load on the same edge as a drain keeps tvalid high (no bubble).
            if (word_done) begin
                m_axis_tvalid <= 1'b1;
            end else if (drain) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef CRC_PACKER_STATS_EN
    logic [15:0] run_len;
    logic [15:0] run_len_next;
    logic [15:0] out_len;

    // Length travels with the tlast word so it is published when that word drains.
    assign run_len_next = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            run_len     <= 16'd0;
            out_len     <= 16'd0;
            frame_bytes <= 16'd0;
            frame_count <= 16'd0;
        end else begin
            if (accept) begin
                run_len <= s_axis_tlast ? 16'd0 : run_len_next;
            end
            if (word_done && s_axis_tlast) begin
                out_len <= run_len_next;
            end
            if (drain && m_axis_tlast) begin
                frame_bytes <= out_len;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_crc32_word_packer.sv
// Bench for axis_crc32_word_packer: fixed vectors, corner sequences and random frames
// against a frame-level model; two instances (default, and PAD 5A / LSB-first).
module tb_axis_crc32_word_packer;

    typedef logic [7:0] u8_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } word_t;
    typedef struct packed { logic [7:0] d; logic l; } tx_t;
    typedef struct packed { logic [15:0] len; logic [15:0] cnt; } st_t;
    typedef struct {
        int          len;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [1:0]  last;
    } vec_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        s_axis_tready, s_tready_b;
    logic [31:0] m_axis_tdata, m_tdata_b;
    logic [3:0]  m_axis_tkeep, m_tkeep_b;
    logic        m_axis_tvalid, m_tvalid_b;
    logic        m_axis_tlast, m_tlast_b;
    logic        frame_done, frame_done_b;
`ifdef CRC_PACKER_STATS_EN
    logic [15:0] frame_bytes, frame_count, frame_bytes_b, frame_count_b;
`endif

    axis_crc32_word_packer dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .frame_done(frame_done)
`ifdef CRC_PACKER_STATS_EN
        , .frame_bytes(frame_bytes), .frame_count(frame_count)
`endif
    );

    axis_crc32_word_packer #(.PAD_BYTE(8'h5A), .MSB_FIRST(1'b0)) dut_b (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_tready_b), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b),
        .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_tlast_b), .frame_done(frame_done_b)
`ifdef CRC_PACKER_STATS_EN
        , .frame_bytes(frame_bytes_b), .frame_count(frame_count_b)
`endif
    );

    always #5 aclk = ~aclk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    bit    rdy_random = 1'b0;
    bit    rdy_fixed = 1'b1;
    bit    drv_busy = 1'b0;
    logic  fd_exp = 1'b0;
    int    mon_bad = 0;
    int    fd_pulses = 0;
    int    exp_frames = 0;
    int    exp_cnt = 0;
    int    oa = 0, ea = 0, ob = 0, eb = 0, os = 0, es = 0;

    tx_t   tx_q[$];
    word_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
    int    exp_len[$];
    int    hs[$];
    st_t   st_obs[$];
    vec_t  tbl[7];

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        m_axis_tready = rdy_random ? ($urandom_range(0, 99) < 70) : rdy_fixed;
    end

    // Collects handshakes and frame_done behaviour; all judging happens in the main process.
    always @(negedge aclk) begin
        if (mon_en) begin
            if (frame_done !== fd_exp) mon_bad++;
            if (frame_done_b !== frame_done) mon_bad++;
            if (s_tready_b !== s_axis_tready) mon_bad++;
            if (frame_done === 1'b1) begin
                fd_pulses++;
`ifdef CRC_PACKER_STATS_EN
                st_obs.push_back('{len: frame_bytes, cnt: frame_count});
                if (frame_bytes_b !== frame_bytes || frame_count_b !== frame_count) mon_bad++;
`endif
            end
        end
        if (!areset && m_axis_tvalid === 1'b1 && m_axis_tready) begin
            obs_a.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
            hs.push_back(cyc);
        end
        if (!areset && m_tvalid_b === 1'b1 && m_axis_tready)
            obs_b.push_back('{d: m_tdata_b, k: m_tkeep_b, l: m_tlast_b});
        fd_exp = !areset && (m_axis_tvalid === 1'b1) && m_axis_tready && m_axis_tlast;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Frame-level model: chop into 4-byte words, place bytes by order, pad the rest.
    function automatic void add_frame(input u8_t fb[$], input bit model_a);
        int    len;
        int    n;
        word_t wa, wb;
        len = fb.size();
        for (int i = 0; i < len; i++) tx_q.push_back('{d: fb[i], l: (i == len - 1)});
        for (int base = 0; base < len; base += 4) begin
            n = (len - base > 4) ? 4 : len - base;
            wa.d = 32'h0;
            wa.k = 4'h0;
            wb.d = {4{8'h5A}};
            wb.k = 4'h0;
            for (int j = 0; j < n; j++) begin
                wa.d[8*(3-j) +: 8] = fb[base+j];
                wa.k[3-j]          = 1'b1;
                wb.d[8*j +: 8]     = fb[base+j];
                wb.k[j]            = 1'b1;
            end
            wa.l = (base + n == len);
            wb.l = wa.l;
            if (model_a) exp_a.push_back(wa);
            exp_b.push_back(wb);
        end
        exp_len.push_back(len);
        exp_frames++;
    endfunction

    task automatic drive_stream(input int gap_pct);
        int guard = 0;
        bit taken = 1'b0;
        drv_busy = 1'b1;
        while (tx_q.size() > 0 && guard < 5000) begin
            @(posedge aclk); #1;
            if (taken) s_axis_tvalid = 1'b0;
            taken = 1'b0;
            if (!s_axis_tvalid && $urandom_range(0, 99) >= gap_pct) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = tx_q[0].d;
                s_axis_tlast  = tx_q[0].l;
            end
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready === 1'b1) begin
                void'(tx_q.pop_front());
                taken = 1'b1;
            end
            guard++;
        end
        chk("driver_budget", 32'(tx_q.size()), 32'd0);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        drv_busy = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((obs_a.size() < exp_a.size() || obs_b.size() < exp_b.size()) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(negedge aclk);
    endtask

    task automatic compare_new(input string tag);
        chk({tag, "_words_a"}, 32'(obs_a.size() - oa), 32'(exp_a.size() - ea));
        chk({tag, "_words_b"}, 32'(obs_b.size() - ob), 32'(exp_b.size() - eb));
        while (oa < obs_a.size() && ea < exp_a.size()) begin
            chk($sformatf("%s_data_a[%0d]", tag, ea), obs_a[oa].d, exp_a[ea].d);
            chk($sformatf("%s_keep_a[%0d]", tag, ea), 32'(obs_a[oa].k), 32'(exp_a[ea].k));
            chk($sformatf("%s_last_a[%0d]", tag, ea), 32'(obs_a[oa].l), 32'(exp_a[ea].l));
            oa++; ea++;
        end
        while (ob < obs_b.size() && eb < exp_b.size()) begin
            chk($sformatf("%s_data_b[%0d]", tag, eb), obs_b[ob].d, exp_b[eb].d);
            chk($sformatf("%s_keep_b[%0d]", tag, eb), 32'(obs_b[ob].k), 32'(exp_b[eb].k));
            chk($sformatf("%s_last_b[%0d]", tag, eb), 32'(obs_b[ob].l), 32'(exp_b[eb].l));
            ob++; eb++;
        end
        oa = obs_a.size(); ea = exp_a.size();
        ob = obs_b.size(); eb = exp_b.size();
        chk({tag, "_frame_done_pulses"}, 32'(fd_pulses), 32'(exp_frames));
`ifdef CRC_PACKER_STATS_EN
        chk({tag, "_stats_events"}, 32'(st_obs.size() - os), 32'(exp_len.size() - es));
        while (os < st_obs.size() && es < exp_len.size()) begin
            exp_cnt++;
            chk($sformatf("%s_frame_bytes[%0d]", tag, es), 32'(st_obs[os].len), 32'(exp_len[es]));
            chk($sformatf("%s_frame_count[%0d]", tag, es), 32'(st_obs[os].cnt), 32'(exp_cnt & 16'hFFFF));
            os++; es++;
        end
        os = st_obs.size(); es = exp_len.size();
`endif
    endtask

    initial begin
        u8_t fb[$];
        int  n;

        tbl[0] = '{8, 64'h0102030405060708, 2, 64'h01020304_05060708, 8'hFF, 2'b01};
        tbl[1] = '{5, 64'hAABBCCDDEE000000, 2, 64'hAABBCCDD_EE000000, 8'hF8, 2'b01};
        tbl[2] = '{1, 64'h7F00000000000000, 1, 64'h7F000000_00000000, 8'h80, 2'b10};
        tbl[3] = '{3, 64'h1122330000000000, 1, 64'h11223300_00000000, 8'hE0, 2'b10};
        tbl[4] = '{2, 64'hC33C000000000000, 1, 64'hC33C0000_00000000, 8'hC0, 2'b10};
        tbl[5] = '{4, 64'hDEADBEEF00000000, 1, 64'hDEADBEEF_00000000, 8'hF0, 2'b10};
        tbl[6] = '{7, 64'h1011121314151600, 2, 64'h10111213_14151600, 8'hFE, 2'b01};

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
        chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef CRC_PACKER_STATS_EN
        chk("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
`endif
        @(posedge aclk); #1;
        areset = 1'b0;
        mon_en = 1'b1;

        rdy_fixed = 1'b1;
        for (int t = 0; t < 7; t++) begin
            fb.delete();
            for (int i = 0; i < tbl[t].len; i++) fb.push_back(tbl[t].bytes[63-8*i -: 8]);
            add_frame(fb, 1'b0);
            for (int w = 0; w < tbl[t].nw; w++)
                exp_a.push_back('{d: tbl[t].data[63-32*w -: 32], k: tbl[t].keep[7-4*w -: 4],
                                  l: tbl[t].last[1-w]});
            drive_stream(0);
            wait_drain();
            compare_new($sformatf("tbl%0d", t));
        end

        // Single-byte frame immediately followed by a 3-byte frame.
        fb = '{8'h7F};
        add_frame(fb, 1'b0);
        exp_a.push_back('{d: 32'h7F000000, k: 4'b1000, l: 1'b1});
        fb = '{8'h11, 8'h22, 8'h33};
        add_frame(fb, 1'b0);
        exp_a.push_back('{d: 32'h11223300, k: 4'b1110, l: 1'b1});
        n = fd_pulses;
        drive_stream(0);
        wait_drain();
        chk("b2b_frame_done_pulses", 32'(fd_pulses - n), 32'd2);
        compare_new("b2b");

        // Backpressure: hold a full word for 10 cycles, then stream with no bubbles.
        rdy_fixed = 1'b0;
        @(posedge aclk); #2;
        fb.delete();
        for (int i = 1; i <= 12; i++) fb.push_back(u8_t'(i));
        add_frame(fb, 1'b1);
        fork
            drive_stream(0);
        join_none
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("bp_valid_seen", 32'(m_axis_tvalid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk($sformatf("bp_s_tready[%0d]", i), 32'(s_axis_tready), 32'd0);
            chk($sformatf("bp_tdata[%0d]", i), m_axis_tdata, 32'h01020304);
        end
        rdy_fixed = 1'b1;
        n = 0;
        #1;
        while (drv_busy && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk("bp_driver_done", 32'(drv_busy), 32'd0);
        wait_drain();
        compare_new("bp");
        if (hs.size() >= 3) begin
            chk("bp_spacing_1", 32'(hs[hs.size()-2] - hs[hs.size()-3]), 32'd4);
            chk("bp_spacing_2", 32'(hs[hs.size()-1] - hs[hs.size()-2]), 32'd4);
        end else begin
            chk("bp_handshakes", 32'(hs.size()), 32'd3);
        end

        // Abort a frame after two bytes with reset; only the following frame appears.
        tx_q.push_back('{d: 8'hAB, l: 1'b0});
        tx_q.push_back('{d: 8'hCD, l: 1'b0});
        drive_stream(0);
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_cnt = 0;
        fb = '{8'h01, 8'h02, 8'h03, 8'h04};
        add_frame(fb, 1'b1);
        drive_stream(0);
        wait_drain();
        compare_new("abort");
        if (obs_a.size() > 0) begin
            chk("abort_word", obs_a[obs_a.size()-1].d, 32'h01020304);
            chk("abort_last", 32'(obs_a[obs_a.size()-1].l), 32'd1);
        end

        // Two frames of 6 and 9 bytes, then random frames under random backpressure.
        for (int len = 6; len <= 9; len += 3) begin
            fb.delete();
            for (int i = 0; i < len; i++) fb.push_back(u8_t'($urandom));
            add_frame(fb, 1'b1);
        end
        drive_stream(0);
        wait_drain();
        compare_new("six_nine");

        rdy_random = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) fb.push_back(u8_t'($urandom));
            add_frame(fb, 1'b1);
        end
        drive_stream(30);
        wait_drain();
        compare_new("rand");

        chk("monitor_errors", 32'(mon_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_crc32_word_packer.md
Name: axis_crc32_word_packer

Overview:
- Byte-to-word packer that sits directly upstream of the CRC-32/MPEG-2 engine.
- Gathers an 8-bit AXI-Stream byte stream (framed by tlast) into 32-bit words, MSB-first, so the engine's s_axis receives whole words.
- Partial final words are padded, and tkeep and tlast are produced for downstream framing logic.
- Built as a one-word accumulator feeding a one-word output register, with full AXI-Stream handshakes on both sides.

Parameters:
- OUT_BYTES, 4: bytes per output word. Only 4 is supported; the CRC engine is 32-bit only.
- PAD_BYTE, 8'h00: value driven on lanes not filled by the final partial word.
- MSB_FIRST, 1: 1 puts the first byte in bits 31:24; 0 puts it in bits 7:0.

Ports:
- aclk, input, 1: clock; all logic on rising edge.
- areset, input, 1: synchronous reset, active-high.
- s_axis_tdata, input, 8: input byte.
- s_axis_tvalid, input, 1: input byte valid.
- s_axis_tready, output, 1: block accepts a byte.
- s_axis_tlast, input, 1: final byte of frame.
- m_axis_tdata, output, 32: packed word.
- m_axis_tkeep, output, 4: lane valid; bit i covers tdata[8i+7:8i].
- m_axis_tvalid, output, 1: output word valid.
- m_axis_tready, input, 1: downstream accepts the word.
- m_axis_tlast, output, 1: word holds the final byte of frame.
- frame_done, output, 1: one-cycle pulse when the tlast word handshakes on m_axis.

Behaviour:
- Clock and reset: one clock aclk; reset areset is synchronous and active-high.
- Reset values:
  - All outputs 0: s_axis_tready=0, m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, frame_done=0.
  - Lane index=0; accumulator lanes=PAD_BYTE.
- Reset mid-frame: the partial accumulator and any unsent output word are discarded. Nothing is emitted for that frame; the first byte after reset is treated as byte 0 of a new frame.
- Internal state:
  - Accumulator of 4 lanes plus a keep mask.
  - Lane index idx, 2-bit, 0..3.
  - Output register out_valid plus tdata/tkeep/tlast.
- s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready). This is the only combinational path (m_axis_tready to s_axis_tready); it does not depend on s_axis_tvalid.
- Byte accept (s_axis_tvalid && s_axis_tready):
  - Byte is written to lane (MSB_FIRST ? 3-idx : idx) and the matching keep bit is set.
- Word completes when the accepted byte has idx==3 or s_axis_tlast=1. On the same edge:
  - The word, including the new byte, loads the output register.
  - m_axis_tvalid goes to 1 and m_axis_tlast takes s_axis_tlast.
  - Unfilled lanes hold PAD_BYTE with keep bits 0.
  - The accumulator resets to PAD_BYTE and keep=0, and idx goes to 0.
- Word does not complete: idx increments.
- Latency: a word is visible on m_axis the cycle after its last byte is accepted.
- Throughput: 1 byte/cycle with no backpressure, i.e. one word per 4 cycles.
- Output handshake (m_axis_tvalid && m_axis_tready):
  - With no new word loading on the same edge, m_axis_tvalid goes to 0. tdata/tkeep/tlast hold their values; they are don't-care while tvalid=0.
  - When a drain and a load happen on the same edge, tvalid stays 1 and the new word replaces the old one (no bubble).
- Stability: while m_axis_tvalid=1 and m_axis_tready=0, tdata/tkeep/tlast are stable and no byte is accepted.
- Full tkeep encodings (MSB_FIRST=1), by number of bytes in the final word:
  - 1 byte: 4'b1000.
  - 2 bytes: 4'b1100.
  - 3 bytes: 4'b1110.
  - 4 bytes: 4'b1111.
  - With MSB_FIRST=0 the encodings mirror.
- Single-byte frame (tlast on byte 0) emits one word with tkeep=1000.
- tlast on idx==3 emits one full word with tlast=1; no empty word follows.
- frame_done: registered, asserted the cycle after the handshake of a word with m_axis_tlast=1. Back-to-back frames produce separate pulses.
- Zero-length frames cannot occur: tlast always accompanies a byte.

Optional Feature:
- Macro: CRC_PACKER_STATS_EN.
- When defined, adds two outputs:
  - frame_bytes, 16-bit: byte length of the last completed frame, updated on the cycle frame_done is asserted; saturates at 16'hFFFF.
  - frame_count, 16-bit: increments once per frame_done, wraps FFFF to 0000.
  - Both reset to 0.
- When not defined, neither port exists and no counter logic is built.

Test Plan:
- 8-byte frame 01..08 with tlast on 08, m_axis_tready=1 -> words 0x01020304 (tkeep F, tlast 0) and 0x05060708 (tkeep F, tlast 1); frame_done pulses once.
- 5-byte frame AA BB CC DD EE -> 0xAABBCCDD then 0xEE000000 with tkeep=1000 and tlast=1; PAD_BYTE=8'h5A variant gives 0xEE5A5A5A.
- m_axis_tready=0 for 10 cycles while a full word is held -> s_axis_tready=0, tdata stable, no byte lost; on release, continuous bytes give a word every 4 cycles with no bubble.
- Single-byte frame 0x7F followed immediately by a 3-byte frame 11 22 33 -> 0x7F000000/1000/last, then 0x11223300/1110/last; two frame_done pulses.
- areset asserted after 2 bytes of a frame, then frame 01..04 -> no output from the aborted frame; output is exactly 0x01020304, tlast=1.
- With CRC_PACKER_STATS_EN, two frames of 6 and 9 bytes -> frame_bytes = 6 then 9; frame_count = 1 then 2.
